// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode codes and FSM state encoding.
package timer_counter_pkg;

    // Register select codes (ADDR[3:2])
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int TC_EN_BIT   = 0;
    localparam int TC_MODE_LSB = 1;
    localparam int TC_MODE_MSB = 2;
    localparam int TC_IM_BIT   = 3;

    // Mode codes; 10/11 fall back to one-shot behaviour
    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // Packed so that the field order matches the CTRL bit positions above
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    // Only the exact reload code reloads; every other code is one-shot
    function automatic logic tc_is_reload(input tc_ctrl_t c);
        return (c.mode == TC_MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Data-memory-side bus between the CPU M stage (master) and the timer (slave).
interface timer_counter_if;
    logic [31:0] ADDR;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        IRQ;

    modport master (
        output ADDR, write_enable, write_data,
        input  read_data, IRQ
    );

    modport slave (
        input  ADDR, write_enable, write_data,
        output read_data, IRQ
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Decodes its own 16-byte window; reads are combinational with no bypass
// of a same-cycle write, and the interrupt request is a masked flag.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    tc_ctrl_t    ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    tc_state_e   state;
    logic        irq_flag;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] rdata;

    assign hit       = (bus.ADDR[31:4] == BASE_ADDR[31:4]);
    assign sel       = bus.ADDR[3:2];
    assign wr_ctrl   = bus.write_enable && hit && (sel == TC_CTRL);
    assign wr_preset = bus.write_enable && hit && (sel == TC_PRESET);

    // Register file, FSM and interrupt flag. CPU writes are applied first so
    // that the FSM's later assignments only override them where intended.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            state    <= TC_IDLE;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= tc_ctrl_t'(bus.write_data[TC_IM_BIT:TC_EN_BIT]);
            if (wr_preset)
                preset <= bus.write_data;
            // Any CPU write to CTRL or PRESET acknowledges a pending interrupt
            if (wr_ctrl || wr_preset)
                irq_flag <= 1'b0;

            unique case (state)
                TC_IDLE: begin
                    if (ctrl.en)
                        state <= TC_LOAD;
                end
                TC_LOAD: begin
                    // Uses the PRESET held before this edge
                    count <= preset;
                    state <= TC_CNT;
                end
                TC_CNT: begin
                    if (!ctrl.en) begin
                        state <= TC_IDLE;
                    end else if (count == 32'd0) begin
                        state    <= TC_INT;
                        irq_flag <= 1'b1;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                TC_INT: begin
                    state <= TC_IDLE;
                    if (tc_is_reload(ctrl)) begin
                        // Reload mode: one-cycle pulse, EN stays set
                        irq_flag <= 1'b0;
                    end else if (!wr_ctrl) begin
                        // One-shot: a same-edge CPU write to CTRL wins
                        ctrl.en <= 1'b0;
                    end
                end
                default: state <= TC_IDLE;
            endcase
        end
    end

    // Combinational read of the selected register; zero outside the window
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            unique case (sel)
                TC_CTRL:   rdata = {28'd0, ctrl};
                TC_PRESET: rdata = preset;
                TC_COUNT:  rdata = count;
                TC_RSVD:   rdata = 32'd0;
                default:   rdata = 32'd0;
            endcase
        end
    end

    assign bus.read_data = rdata;
    assign bus.IRQ       = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one task per scenario, expected values
// hand-derived from the edge timing of the countdown FSM.
module tb_timer_counter;

    localparam logic [31:0] BASE  = 32'h0000_7F00;
    localparam logic [31:0] A_CTL = BASE + 32'h0;
    localparam logic [31:0] A_PRE = BASE + 32'h4;
    localparam logic [31:0] A_CNT = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
    localparam logic [31:0] A_OUT = BASE + 32'h10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    timer_counter_if bus ();

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        bus.ADDR = addr;
        #1;
        v = bus.read_data;
    endtask

    // Write lands on the next edge; returns just after that edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.ADDR         = addr;
        bus.write_data   = data;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
        bus.write_data   = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [4];
        addrs = '{A_CTL, A_PRE, A_CNT, A_RSV};
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        foreach (addrs[i]) begin
            rd(addrs[i], v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], v, 32'd0);
            end
        end
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", bus.IRQ);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(A_PRE, 32'd3);
        wr(A_CTL, 32'h9);            // edge 0
        tick();                      // +1 LOAD
        for (int k = 2; k <= 5; k++) begin
            tick();
            rd(A_CNT, v);
            checks++;
            if (v !== 32'(5 - k)) begin
                failures++;
                $display("FAIL oneshot_count edge=+%0d got=%0d exp=%0d", k, v, 5 - k);
            end
        end
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_early got=%b exp=0", bus.IRQ);
        end
        tick();                      // +6 INT
        checks++;
        if (bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_rise got=%b exp=1", bus.IRQ);
        end
        tick();
        tick();
        tick();                      // +9, still sticky
        checks++;
        if (bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_sticky got=%b exp=1", bus.IRQ);
        end
        rd(A_CTL, v);
        checks++;
        if (v !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_ctrl_en_clr got=%h exp=%h", v, 32'h8);
        end
        wr(A_CTL, 32'h0);
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_ack got=%b exp=0", bus.IRQ);
        end
    endtask

    task automatic test_reload();
        logic [31:0] v;
        logic        exp;
        wr(A_PRE, 32'd2);
        wr(A_CTL, 32'hB);            // edge 0; INT at +5, +11, +17
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = (k == 5) || (k == 11) || (k == 17);
            checks++;
            if (bus.IRQ !== exp) begin
                failures++;
                $display("FAIL reload_irq edge=+%0d got=%b exp=%b", k, bus.IRQ, exp);
            end
        end
        rd(A_CTL, v);
        checks++;
        if (v !== 32'hB) begin
            failures++;
            $display("FAIL reload_ctrl got=%h exp=%h", v, 32'hB);
        end
        wr(A_CTL, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_masked();
        logic [31:0] v;
        logic        seen;
        seen = 1'b0;
        wr(A_PRE, 32'd1);
        wr(A_CTL, 32'h1);            // INT at +4, flag set but masked
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (bus.IRQ !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL masked_irq got=%b exp=0", seen);
        end
        wr(A_CTL, 32'h8);            // unmask; write also clears the flag
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL masked_unmask_irq got=%b exp=0", bus.IRQ);
        end
        tick();
        rd(A_CTL, v);
        checks++;
        if (v !== 32'h8 || bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL masked_after ctrl=%h irq=%b exp ctrl=%h irq=0", v, bus.IRQ, 32'h8);
        end
        wr(A_CTL, 32'h0);
    endtask

    task automatic test_pause();
        logic [31:0] v;
        wr(A_PRE, 32'd10);
        wr(A_CTL, 32'h1);            // edge 0; COUNT=10 at +2, 5 at +7
        for (int k = 1; k <= 7; k++) tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd5) begin
            failures++;
            $display("FAIL pause_pre got=%0d exp=5", v);
        end
        wr(A_CTL, 32'h0);            // edge +8 still decrements, +9 -> IDLE
        tick();
        tick();
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd4) begin
            failures++;
            $display("FAIL pause_frozen got=%0d exp=4", v);
        end
        wr(A_CNT, 32'hFFFF);
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd4) begin
            failures++;
            $display("FAIL count_write_ignored got=%h exp=%h", v, 32'd4);
        end
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL reserved_read got=%h exp=0", v);
        end
        wr(A_OUT, 32'h0000_123D);
        rd(A_OUT, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL out_of_window_read got=%h exp=0", v);
        end
        rd(A_CTL, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL out_of_window_ctrl got=%h exp=0", v);
        end
        rd(A_PRE, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("FAIL preset_kept got=%0d exp=10", v);
        end
        // Restart from IDLE, then rewrite PRESET mid-count
        wr(A_CTL, 32'h1);            // edge 0
        tick();
        tick();                      // +2 COUNT=10
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("FAIL restart_load got=%0d exp=10", v);
        end
        wr(A_PRE, 32'd3);            // +3, COUNT keeps counting
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd9) begin
            failures++;
            $display("FAIL preset_mid_count got=%0d exp=9", v);
        end
        wr(A_CTL, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] v;
        wr(A_PRE, 32'd1);
        wr(A_CTL, 32'h9);            // edge 0; INT at +4, INT->IDLE at +5
        tick();
        tick();
        tick();                      // +3
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL collide_pre_irq got=%b exp=0", bus.IRQ);
        end
        tick();                      // +4 INT
        checks++;
        if (bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL collide_irq_rise got=%b exp=1", bus.IRQ);
        end
        wr(A_CTL, 32'h9);            // lands on +5
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL collide_irq_clear got=%b exp=0", bus.IRQ);
        end
        rd(A_CTL, v);
        checks++;
        if (v !== 32'h9) begin
            failures++;
            $display("FAIL collide_en_kept got=%h exp=%h", v, 32'h9);
        end
        tick();                      // +6 LOAD
        tick();                      // +7 COUNT=1
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("FAIL collide_reload got=%0d exp=1", v);
        end
        tick();
        tick();                      // +9 INT again
        checks++;
        if (bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL collide_second_irq got=%b exp=1", bus.IRQ);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(A_PRE, 32'd5);
        wr(A_CTL, 32'h9);
        tick();
        tick();
        tick();                      // counting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midreset_count got=%h exp=0", v);
        end
        rd(A_CTL, v);
        checks++;
        if (v !== 32'd0 || bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl ctrl=%h irq=%b exp ctrl=0 irq=0", v, bus.IRQ);
        end
        tick();
        tick();
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midreset_idle got=%h exp=0", v);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.ADDR         = 32'd0;
        bus.write_enable = 1'b0;
        bus.write_data   = 32'd0;
        test_reset();
        test_oneshot();
        test_reload();
        test_masked();
        test_pause();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
